// File: rtl/ram_port_arbiter_if.sv
// Two-requester single-port RAM access bundle: requester handshakes, read returns and the RAM port A.
// The slave side is the arbiter; the master side is the environment (requesters plus the RAM itself).
`timescale 1ns/1ps
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] din1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr_a;
    logic [DATA_WIDTH-1:0] ram_din_a;
    logic [DATA_WIDTH-1:0] ram_dout_a;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, din0, din1, ram_dout_a,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_we, ram_addr_a, ram_din_a
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, din0, din1, ram_dout_a,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_we, ram_addr_a, ram_din_a
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto one RAM port with a bounded burst per owner and round-robin tie-break.
// Grants are combinational (zero latency); read data valid one cycle after a granted read.
`timescale 1ns/1ps
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rv0_q, rv1_q;
    logic       g0, g1;

    always_comb begin
        g0      = 1'b0;
        g1      = 1'b0;
        state_d = IDLE;
        ptr_d   = ptr_q;
        cnt_d   = 4'd0;

        // Grants are forced low during reset regardless of requests.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (bus.req0 && bus.req1) begin
                        g0 = ~ptr_q;
                        g1 = ptr_q;
                    end else begin
                        g0 = bus.req0;
                        g1 = bus.req1;
                    end
                end
                OWN0: begin
                    if (bus.req0 && (cnt_q < BMAX || !bus.req1)) g0 = 1'b1;
                    else                                         g1 = bus.req1;
                end
                OWN1: begin
                    if (bus.req1 && (cnt_q < BMAX || !bus.req0)) g1 = 1'b1;
                    else                                         g0 = bus.req0;
                end
                default: ;
            endcase
        end

        // A switch of owner hands priority to the loser; a repeat grant just extends the burst.
        if (g0) begin
            state_d = OWN0;
            if (state_q == OWN0) begin
                cnt_d = (cnt_q == BMAX) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
                ptr_d = 1'b1;
            end
        end else if (g1) begin
            state_d = OWN1;
            if (state_q == OWN1) begin
                cnt_d = (cnt_q == BMAX) ? cnt_q : cnt_q + 4'd1;
            end else begin
                cnt_d = 4'd1;
                ptr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= 4'd0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rv0_q   <= g0 & ~bus.we0;
            rv1_q   <= g1 & ~bus.we1;
        end
    end

    assign bus.gnt0       = g0;
    assign bus.gnt1       = g1;
    assign bus.ram_we     = (g0 & bus.we0) | (g1 & bus.we1);
    assign bus.ram_addr_a = g0 ? bus.addr0 : (g1 ? bus.addr1 : {ADDR_WIDTH{1'b0}});
    assign bus.ram_din_a  = g0 ? bus.din0  : (g1 ? bus.din1  : {DATA_WIDTH{1'b0}});
    // Gating with reset kills a read return that lands in the first reset cycle.
    assign bus.rvalid0    = rv0_q & ~reset;
    assign bus.rvalid1    = rv1_q & ~reset;
    assign bus.rdata0     = bus.ram_dout_a;
    assign bus.rdata1     = bus.ram_dout_a;
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, which is the RAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, which is the RAM data width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, which is the maximum number of consecutive grants to one requester while the other is waiting; legal range is 1 to 15.
REQ-004 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  is a synchronous, active-high reset.
REQ-006 req0, req1  input  1 each  are access requests from requesters 0 and 1.
REQ-007 we0, we1  input  1 each  select the access type: 1 = write, 0 = read.
REQ-008 addr0, addr1  input  ADDR_WIDTH each  are the access addresses.
REQ-009 din0, din1  input  DATA_WIDTH each  are the write data.
REQ-010 gnt0, gnt1  output  1 each  are combinational grants; the access is performed in the cycle the grant is high.
REQ-011 rvalid0, rvalid1  output  1 each  are registered read-data-valid flags.
REQ-012 rdata0, rdata1  output  DATA_WIDTH each  are the read data, driven from ram_dout_a.
REQ-013 ram_we  output  1  is the RAM write enable.
REQ-014 ram_addr_a  output  ADDR_WIDTH  is the RAM port-A address.
REQ-015 ram_din_a  output  DATA_WIDTH  is the RAM port-A write data.
REQ-016 ram_dout_a  input  DATA_WIDTH  is the RAM port-A read data, valid the cycle after the address is presented.

Function
REQ-017 The FSM SHALL have the states IDLE, OWN0 and OWN1; it SHALL also hold a 1-bit priority pointer ptr and a 4-bit burst counter cnt.
REQ-018 In IDLE with exactly one req high, the block SHALL grant that requester in the same cycle.
REQ-019 In IDLE with both req high, the block SHALL grant requester ptr.
REQ-020 In IDLE with no req high, the block SHALL issue no grant and stay in IDLE.
REQ-021 In OWNk, the block SHALL grant k again when reqk=1 and either cnt<BURST_MAX or req of the other requester is 0.
REQ-022 In OWNk, when reqk=0, or when cnt=BURST_MAX while the other requester is requesting, the block SHALL grant the other requester in the same cycle if it is requesting, with no dead cycle; otherwise it SHALL issue no grant.
REQ-023 On granting a different requester j (including from IDLE), the block SHALL move to OWNj, set cnt=1 and set ptr to the requester that was not granted.
REQ-024 On granting the same owner again, cnt SHALL increment and saturate at BURST_MAX.
REQ-025 A cycle with no grant SHALL move the FSM to IDLE and leave ptr unchanged.
REQ-026 At most one of gnt0 and gnt1 SHALL be high in any cycle.
REQ-027 No grant SHALL be issued to a requester whose req is 0.
REQ-028 While gntk is high, ram_addr_a SHALL equal addrk, ram_din_a SHALL equal dink and ram_we SHALL equal wek.
REQ-029 With no grant, ram_we SHALL be 0 and ram_addr_a and ram_din_a SHALL be 0.
REQ-030 A read granted to requester k in cycle T SHALL assert rvalidk for exactly cycle T+1, with rdatak = ram_dout_a in that cycle.
REQ-031 Writes SHALL never assert rvalid.
REQ-032 Back-to-back reads SHALL produce one rvalid per cycle.
REQ-033 rdata0 and rdata1 SHALL both continuously mirror ram_dout_a; their contents are meaningful only while the matching rvalid is high.
REQ-034 With BURST_MAX=1, the block SHALL alternate grants every cycle while both requesters are requesting.

Reset
REQ-035 While reset=1, the block SHALL drive gnt0=gnt1=0 and ram_we=0, and SHALL set the FSM to IDLE, ptr=0 and cnt=0.
REQ-036 At the first clock edge with reset=1, the block SHALL clear rvalid0 and rvalid1 to 0, and they SHALL remain 0 while reset stays high.
REQ-037 A reset asserted in the cycle after a granted read SHALL suppress that read's rvalid.
REQ-038 A reset asserted mid-burst SHALL abandon the burst; after reset, arbitration SHALL restart from IDLE with ptr=0.

Verification
REQ-039 After reset: req0=req1=1, both reads, held for 10 cycles -> gnt pattern 0,0,0,0,1,1,1,1,0,0; rvalid follows each grant by 1 cycle.
REQ-040 After reset: req1 only, we1=1, addr1=5, din1=0xA5, for 1 cycle; then req0 read addr0=5 -> ram_we=1, ram_addr_a=5 at the write; rvalid0=1 with rdata0=0xA5 two cycles after the write.
REQ-041 req0 alone held for 8 cycles with BURST_MAX=4 -> gnt0 high in all 8 cycles; gnt1 never high.
REQ-042 OWN0 with cnt=2, req0 drops while req1=1 -> gnt1 in the same cycle; state OWN1, cnt=1.
REQ-043 Read granted in cycle T and reset asserted in T+1 -> rvalid low in T+1; all outputs at reset values; next grant goes to ptr=0.
REQ-044 Random req/we/addr traffic against a reference memory model -> read data matches and grant checks hold: one-hot-or-zero, no grant without req, starvation bounded by BURST_MAX cycles.
